// File: rtl/tone_monitor.sv
// Multi-channel tone checker: moving-average smoothing, zero-crossing period
// and peak measurement, window checks with saturating error counters.
module tone_monitor #(
    parameter int NUM_CH   = 2,
    parameter int WIDTH    = 16,
    parameter int AVG_LOG2 = 0,
    parameter int CNT_W    = 12,
    parameter int ERR_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      smp_vld,
    input  logic [NUM_CH*WIDTH-1:0]   smp_in,
    input  logic [CNT_W-1:0]          min_period,
    input  logic [CNT_W-1:0]          max_period,
    input  logic [WIDTH-2:0]          min_ampl,
    input  logic [WIDTH-2:0]          max_ampl,
    output logic [NUM_CH-1:0]         meas_vld,
    output logic [NUM_CH*CNT_W-1:0]   period_out,
    output logic [NUM_CH*WIDTH-1:0]   peak_out,
    output logic [NUM_CH*ERR_W-1:0]   freq_err_cnt,
    output logic [NUM_CH*ERR_W-1:0]   ampl_err_cnt,
    output logic [NUM_CH-1:0]         locked
);
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = WIDTH + AVG_LOG2;
    localparam logic [AVG_LOG2:0] FILL_LAST = (AVG_LOG2+1)'(DEPTH - 1);

    typedef enum logic [1:0] {FILL, ARM, SKIP, MEAS} state_t;

    // High in the cycle after a sample: the only cycle crossings and FSMs are evaluated.
    logic eval_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      eval_q <= 1'b0;
        else if (clr) eval_q <= 1'b0;
        else          eval_q <= smp_vld;
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic signed [WIDTH-1:0] smp;
        logic signed [WIDTH-1:0] oldest;
        logic signed [WIDTH-1:0] smooth_d;
        logic signed [WIDTH-1:0] smooth_q;
        logic signed [WIDTH-1:0] prev_q;
        logic signed [SUM_W-1:0] sum_d;
        logic signed [SUM_W-1:0] sum_q;
        logic                    xing;

        state_t                  state_q, state_d;
        logic [AVG_LOG2:0]       fill_q, fill_d;
        logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
        logic signed [WIDTH-1:0] pk_q, pk_d, pk_new;
        logic [WIDTH-1:0]        pk_mag;
        logic [CNT_W-1:0]        per_q, per_d;
        logic signed [WIDTH-1:0] peak_q, peak_d;
        logic                    mv_q, mv_d;
        logic [ERR_W-1:0]        fe_q, fe_d, ae_q, ae_d;
        logic                    per_bad, amp_bad;

        assign smp = $signed(smp_in[gi*WIDTH +: WIDTH]);

        if (AVG_LOG2 == 0) begin : g_direct
            // Depth 1: the entry being replaced is the whole running sum.
            assign oldest = sum_q;
        end else begin : g_hist
            logic signed [WIDTH-1:0] hist_q [DEPTH];
            logic [AVG_LOG2-1:0]     wr_ptr_q;

            assign oldest = hist_q[wr_ptr_q];

            always_ff @(posedge clk or posedge rst) begin
                if (rst || clr) begin
                    for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
                    wr_ptr_q <= '0;
                end else if (smp_vld) begin
                    hist_q[wr_ptr_q] <= smp;
                    wr_ptr_q         <= wr_ptr_q + AVG_LOG2'(1);
                end
            end
        end

        assign sum_d    = sum_q + SUM_W'(smp) - SUM_W'(oldest);
        assign smooth_d = WIDTH'(sum_d >>> AVG_LOG2);
        assign xing     = eval_q && prev_q[WIDTH-1] && !smooth_q[WIDTH-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sum_q    <= '0;
                smooth_q <= '0;
                prev_q   <= '0;
            end else if (clr) begin
                sum_q    <= '0;
                smooth_q <= '0;
                prev_q   <= '0;
            end else if (smp_vld) begin
                sum_q    <= sum_d;
                smooth_q <= smooth_d;
                prev_q   <= smooth_q;
            end
        end

        assign cnt_inc = cnt_q + CNT_W'(1);
        assign pk_new  = (smooth_q > pk_q) ? smooth_q : pk_q;
        // Running peak starts at 0 and only grows, so it is never negative here.
        assign pk_mag  = pk_new;
        assign per_bad = (cnt_inc < min_period) || (cnt_inc > max_period);
        assign amp_bad = (pk_mag < {1'b0, min_ampl}) || (pk_mag > {1'b0, max_ampl});

        always_comb begin
            state_d = state_q;
            fill_d  = fill_q;
            cnt_d   = cnt_q;
            pk_d    = pk_q;
            per_d   = per_q;
            peak_d  = peak_q;
            mv_d    = 1'b0;
            fe_d    = fe_q;
            ae_d    = ae_q;
            if (eval_q) begin
                case (state_q)
                    FILL: begin
                        if (fill_q == FILL_LAST) state_d = ARM;
                        else                     fill_d  = fill_q + (AVG_LOG2+1)'(1);
                    end
                    ARM: begin
                        if (xing) state_d = SKIP;
                    end
                    SKIP: begin
                        if (xing) begin
                            state_d = MEAS;
                            cnt_d   = '0;
                            pk_d    = '0;
                        end
                    end
                    MEAS: begin
                        if (xing) begin
                            per_d  = cnt_inc;
                            peak_d = pk_new;
                            mv_d   = 1'b1;
                            if (per_bad && fe_q != '1) fe_d = fe_q + ERR_W'(1);
                            if (amp_bad && ae_q != '1) ae_d = ae_q + ERR_W'(1);
                            cnt_d  = '0;
                            pk_d   = '0;
                        end else if (cnt_inc == '1) begin
                            // No crossing within the counter range: report and re-arm.
                            per_d   = '1;
                            mv_d    = 1'b1;
                            if (fe_q != '1) fe_d = fe_q + ERR_W'(1);
                            cnt_d   = '0;
                            pk_d    = '0;
                            state_d = ARM;
                        end else begin
                            cnt_d = cnt_inc;
                            pk_d  = pk_new;
                        end
                    end
                    default: state_d = FILL;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= FILL;
                fill_q  <= '0;
                cnt_q   <= '0;
                pk_q    <= '0;
                per_q   <= '0;
                peak_q  <= '0;
                mv_q    <= 1'b0;
                fe_q    <= '0;
                ae_q    <= '0;
            end else if (clr) begin
                state_q <= FILL;
                fill_q  <= '0;
                cnt_q   <= '0;
                pk_q    <= '0;
                per_q   <= '0;
                peak_q  <= '0;
                mv_q    <= 1'b0;
                fe_q    <= '0;
                ae_q    <= '0;
            end else begin
                state_q <= state_d;
                fill_q  <= fill_d;
                cnt_q   <= cnt_d;
                pk_q    <= pk_d;
                per_q   <= per_d;
                peak_q  <= peak_d;
                mv_q    <= mv_d;
                fe_q    <= fe_d;
                ae_q    <= ae_d;
            end
        end

        assign meas_vld[gi]                     = mv_q;
        assign period_out[gi*CNT_W +: CNT_W]    = per_q;
        assign peak_out[gi*WIDTH +: WIDTH]      = peak_q;
        assign freq_err_cnt[gi*ERR_W +: ERR_W]  = fe_q;
        assign ampl_err_cnt[gi*ERR_W +: ERR_W]  = ae_q;
        assign locked[gi]                       = (state_q == MEAS);
    end

endmodule

// File: tb/tb_tone_monitor.sv
// Scoreboard bench for tone_monitor: a two-channel unsmoothed instance (sine
// stimulus) and a one-channel AVG_LOG2=3 / CNT_W=8 / ERR_W=2 instance.
module tb_tone_monitor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int per;
        int pk;     // -1: peak not checked
        int fe;
        int ae;
    } exp_t;

    // ---------------- instance A: defaults ----------------
    logic        a_rst, a_clr, a_vld;
    logic [31:0] a_smp;
    logic [11:0] a_minp, a_maxp;
    logic [14:0] a_mina, a_maxa;
    logic [1:0]  a_meas, a_locked;
    logic [23:0] a_period;
    logic [31:0] a_peak;
    logic [15:0] a_fe, a_ae;

    tone_monitor dut_a (
        .clk(clk), .rst(a_rst), .clr(a_clr), .smp_vld(a_vld), .smp_in(a_smp),
        .min_period(a_minp), .max_period(a_maxp), .min_ampl(a_mina), .max_ampl(a_maxa),
        .meas_vld(a_meas), .period_out(a_period), .peak_out(a_peak),
        .freq_err_cnt(a_fe), .ampl_err_cnt(a_ae), .locked(a_locked)
    );

    // ---------------- instance B: smoothing, short counters ----------------
    logic        b_rst, b_clr, b_vld;
    logic [15:0] b_smp;
    logic [7:0]  b_minp, b_maxp;
    logic [14:0] b_mina, b_maxa;
    logic [0:0]  b_meas, b_locked;
    logic [7:0]  b_period;
    logic [15:0] b_peak;
    logic [1:0]  b_fe, b_ae;

    tone_monitor #(.NUM_CH(1), .WIDTH(16), .AVG_LOG2(3), .CNT_W(8), .ERR_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .clr(b_clr), .smp_vld(b_vld), .smp_in(b_smp),
        .min_period(b_minp), .max_period(b_maxp), .min_ampl(b_mina), .max_ampl(b_maxa),
        .meas_vld(b_meas), .period_out(b_period), .peak_out(b_peak),
        .freq_err_cnt(b_fe), .ampl_err_cnt(b_ae), .locked(b_locked)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycle bookkeeping for output latency relative to the last accepted sample.
    int cyc = 0, a_last = 0, b_last = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_vld) a_last <= cyc;
        if (b_vld) b_last <= cyc;
    end

    exp_t qa[2][$];
    exp_t qb[$];

    always @(negedge clk) begin
        for (int ch = 0; ch < 2; ch++) begin
            if (a_meas[ch] === 1'b1) begin
                chk($sformatf("a%0d_meas_expected", ch), qa[ch].size() != 0, 1);
                if (qa[ch].size() != 0) begin
                    exp_t e;
                    e = qa[ch].pop_front();
                    chk($sformatf("a%0d_period", ch), a_period[ch*12 +: 12], e.per);
                    chk($sformatf("a%0d_peak", ch), $signed(a_peak[ch*16 +: 16]), e.pk);
                    chk($sformatf("a%0d_freq_err", ch), a_fe[ch*8 +: 8], e.fe);
                    chk($sformatf("a%0d_ampl_err", ch), a_ae[ch*8 +: 8], e.ae);
                    chk($sformatf("a%0d_latency", ch), cyc - a_last, 2);
                    $display("[TB] A ch%0d meas period=%0d peak=%0d fe=%0d ae=%0d", ch,
                             a_period[ch*12 +: 12], $signed(a_peak[ch*16 +: 16]),
                             a_fe[ch*8 +: 8], a_ae[ch*8 +: 8]);
                end
            end
        end
        if (b_meas[0] === 1'b1) begin
            chk("b_meas_expected", qb.size() != 0, 1);
            if (qb.size() != 0) begin
                exp_t e;
                e = qb.pop_front();
                chk("b_period", b_period, e.per);
                if (e.pk >= 0) chk("b_peak", $signed(b_peak), e.pk);
                chk("b_freq_err", b_fe, e.fe);
                chk("b_ampl_err", b_ae, e.ae);
                chk("b_latency", cyc - b_last, 2);
                $display("[TB] B meas period=%0d peak=%0d fe=%0d ae=%0d",
                         b_period, $signed(b_peak), b_fe, b_ae);
            end
        end
    end

    // ---------------- model of the A stimulus and expected measurements ----------------
    int a_ph[2], a_per[2], a_per_nx[2], a_amp[2], a_amp_nx[2];
    int a_prev[2], a_cnt[2], a_mx[2], a_xc[2], a_fem[2], a_aem[2];

    task automatic a_model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            a_ph[ch] = 0; a_prev[ch] = 0; a_cnt[ch] = 0; a_mx[ch] = 0;
            a_xc[ch] = 0; a_fem[ch] = 0; a_aem[ch] = 0;
            a_per[ch] = a_per_nx[ch];
            a_amp[ch] = a_amp_nx[ch];
            qa[ch].delete();
        end
    endtask

    task automatic a_sample();
        logic [31:0] word;
        for (int ch = 0; ch < 2; ch++) begin
            real r;
            int  v;
            exp_t e;
            r = a_amp[ch] * $sin(2.0 * 3.141592653589793 * (a_ph[ch] + 0.5) / a_per[ch]);
            v = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
            word[ch*16 +: 16] = v[15:0];
            a_cnt[ch]++;
            if (v > a_mx[ch]) a_mx[ch] = v;
            if (a_prev[ch] < 0 && v >= 0) begin
                a_xc[ch]++;
                if (a_xc[ch] >= 3) begin
                    if ((a_cnt[ch] < int'(a_minp) || a_cnt[ch] > int'(a_maxp)) && a_fem[ch] < 255) a_fem[ch]++;
                    if ((a_mx[ch] < int'(a_mina) || a_mx[ch] > int'(a_maxa)) && a_aem[ch] < 255) a_aem[ch]++;
                    e.per = a_cnt[ch]; e.pk = a_mx[ch]; e.fe = a_fem[ch]; e.ae = a_aem[ch];
                    qa[ch].push_back(e);
                end
                a_cnt[ch] = 0;
                a_mx[ch]  = 0;
            end
            a_prev[ch] = v;
            a_ph[ch]++;
            if (a_ph[ch] == a_per[ch]) begin
                a_ph[ch]  = 0;
                a_per[ch] = a_per_nx[ch];
                a_amp[ch] = a_amp_nx[ch];
            end
        end
        @(negedge clk);
        a_smp = word;
        a_vld = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        repeat (18) @(negedge clk);
    endtask

    task automatic a_run(input int n);
        for (int i = 0; i < n; i++) a_sample();
    endtask

    task automatic a_chk_zero(input string tag);
        chk({tag, "_meas"}, a_meas, 0);
        chk({tag, "_period"}, a_period, 0);
        chk({tag, "_peak"}, a_peak, 0);
        chk({tag, "_fe"}, a_fe, 0);
        chk({tag, "_ae"}, a_ae, 0);
        chk({tag, "_locked"}, a_locked, 0);
    endtask

    task automatic b_send(input int v);
        @(negedge clk);
        b_smp = v[15:0];
        b_vld = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic b_block(input int v, input int n);
        for (int i = 0; i < n; i++) b_send(v);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fe_e;
        exp_t e;
        a_rst = 1'b1; a_clr = 1'b0; a_vld = 1'b0; a_smp = '0;
        a_minp = 12'd35; a_maxp = 12'd65; a_mina = 15'd375; a_maxa = 15'd625;
        b_rst = 1'b1; b_clr = 1'b0; b_vld = 1'b0; b_smp = '0;
        b_minp = 8'd1; b_maxp = 8'd255; b_mina = 15'd0; b_maxa = 15'd32767;
        for (int ch = 0; ch < 2; ch++) begin a_per_nx[ch] = 50; a_amp_nx[ch] = 500; end
        a_model_reset();
        repeat (3) @(negedge clk);
        a_chk_zero("a_reset");
        chk("b_reset_locked", b_locked, 0);
        chk("b_reset_fe", b_fe, 0);
        a_rst = 1'b0;
        b_rst = 1'b0;

        // Test 1: period 50, amplitude 500 on both channels.
        a_run(100);
        chk("t1_locked_before_2nd_xing", a_locked, 2'b00);
        a_run(1);
        chk("t1_locked_after_2nd_xing", a_locked, 2'b11);
        a_run(200);
        chk("t1_sb_empty0", qa[0].size(), 0);
        chk("t1_sb_empty1", qa[1].size(), 0);
        chk("t1_fe", a_fe, 0);
        chk("t1_ae", a_ae, 0);
        chk("t1_peak0_near500", ($signed(a_peak[15:0]) >= 499 && $signed(a_peak[15:0]) <= 501), 1);

        // Test 2: left channel moves to period 100 at its next cycle boundary.
        a_per_nx[0] = 100;
        a_run(400);
        chk("t2_left_fe", a_fe[7:0], 3);
        chk("t2_right_fe", a_fe[15:8], 0);
        chk("t2_right_ae", a_ae[15:8], 0);
        chk("t2_left_period", a_period[11:0], 100);

        // Test 3: clear, then amplitude 800 at period 50.
        @(negedge clk); a_clr = 1'b1;
        @(negedge clk); a_clr = 1'b0;
        a_chk_zero("t3_clr");
        for (int ch = 0; ch < 2; ch++) begin a_per_nx[ch] = 50; a_amp_nx[ch] = 800; end
        a_model_reset();
        a_run(351);
        chk("t3_ae0", a_ae[7:0], 5);
        chk("t3_ae1", a_ae[15:8], 5);
        chk("t3_fe", a_fe, 0);
        chk("t3_peak1", $signed(a_peak[31:16]), 800);

        // Reset in the middle of a measurement: immediate clear, nothing reported later.
        a_run(25);
        chk("t5_locked_pre_rst", a_locked, 2'b11);
        #2 a_rst = 1'b1;
        #1 a_chk_zero("t5_async_rst");
        a_model_reset();
        repeat (3) @(negedge clk);
        a_rst = 1'b0;
        a_run(60);
        chk("t5_post_rst_locked", a_locked, 0);
        chk("t5_post_rst_period", a_period, 0);

        // Test 5: step 0 -> 800 through an 8-deep average.
        for (int k = 1; k <= 8; k++) begin
            b_send(800);
            chk($sformatf("t5_smooth_%0d", k), dut_b.g_ch[0].smooth_q, (800 * k) >>> 3);
        end
        @(negedge clk); b_clr = 1'b1;
        @(negedge clk); b_clr = 1'b0;
        chk("t4_clr_smooth", dut_b.g_ch[0].smooth_q, 0);

        // Test 4: lock on a +-400 square wave, then DC -100 until the period counter times out.
        b_block(-400, 8);
        b_block(400, 8);
        b_block(-400, 8);
        b_block(400, 3);
        chk("t4_locked_pre", b_locked, 0);
        b_send(400);
        chk("t4_locked", b_locked, 1);
        e.per = 255; e.pk = -1; e.fe = 1; e.ae = 0;
        qb.push_back(e);
        b_block(400, 4);
        b_block(-100, 250);
        chk("t4_no_early_timeout", qb.size(), 1);
        chk("t4_locked_254", b_locked, 1);
        b_send(-100);
        chk("t4_timeout_seen", qb.size(), 0);
        chk("t4_locked_after", b_locked, 0);
        chk("t4_period", b_period, 255);
        chk("t4_fe", b_fe, 1);
        chk("t4_ae", b_ae, 0);

        // clr together with a sample: sample dropped, channel back to FILL with zeroed counters.
        @(negedge clk);
        b_smp = 16'd1000; b_vld = 1'b1; b_clr = 1'b1;
        @(negedge clk);
        b_vld = 1'b0; b_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_clr_fe", b_fe, 0);
        chk("t6_clr_period", b_period, 0);
        chk("t6_clr_locked", b_locked, 0);
        chk("t6_clr_smooth", dut_b.g_ch[0].smooth_q, 0);
        chk("t6_clr_state_fill", dut_b.g_ch[0].state_q, 0);

        // Test 6: period 16 against window 100..200, counter saturates at 3.
        b_minp = 8'd100; b_maxp = 8'd200; b_mina = 15'd0; b_maxa = 15'd1000;
        fe_e = 0;
        b_block(-400, 8);
        for (int blk = 0; blk < 8; blk++) begin
            b_block(400, 3);
            if (blk >= 2) begin
                fe_e = (fe_e == 3) ? 3 : fe_e + 1;
                e.per = 16; e.pk = 400; e.fe = fe_e; e.ae = 0;
                qb.push_back(e);
            end
            b_block(400, 5);
            b_block(-400, 8);
        end
        chk("t6_sb_empty", qb.size(), 0);
        chk("t6_fe_sat", b_fe, 3);
        chk("t6_ae", b_ae, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
